int_tx_dec: RTL and testbench

Parametrised binary-to-ASCII decimal transmitter interface between the ALU result and the UART TX FIFO. On a start request it pops one result, converts it to decimal with a double-dabble pass and pushes the digits most-significant first into the output FIFO. Each FIFO character is one byte. The block honours `fifo_full` back-pressure, suppresses leading zeros, optionally prints a sign, and optionally appends a terminator. It replaces the fixed 8-bit unsigned formatter in the BIP TX path.

---
 rtl/int_tx_dec_if.sv | 30 +++
 rtl/int_tx_dec.sv | 183 ++++++++++++++++++
 tb/tb_int_tx_dec.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_tx_dec_if.sv
`default_nettype none
// ============================================================================
// Module   : int_tx_dec_if
// Purpose  : Handshake bundle between the ALU result FIFO, the decimal
//            transmitter and the UART TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface int_tx_dec_if #(
    parameter int NBIT = 16
);
    logic            enviar;
    logic [NBIT-1:0] DATO_ALU;
    logic            fifo_full;
    logic            RD_FIFO_IN;
    logic            WR_FIFO_OUT;
    logic [7:0]      data_fifo;
    logic            busy;
    logic [2:0]      STATE;

    modport master (
        output enviar, DATO_ALU, fifo_full,
        input  RD_FIFO_IN, WR_FIFO_OUT, data_fifo, busy, STATE
    );

    modport slave (
        input  enviar, DATO_ALU, fifo_full,
        output RD_FIFO_IN, WR_FIFO_OUT, data_fifo, busy, STATE
    );
endinterface
`default_nettype wire

// File: rtl/int_tx_dec.sv
`default_nettype none
// ============================================================================
// Module   : int_tx_dec
// Purpose  : Pops one ALU result, converts it to decimal by double-dabble and
//            pushes the ASCII digits (optional sign / terminator) to the TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module int_tx_dec #(
    parameter int         NBIT      = 16,
    parameter int         NDIG      = 5,
    parameter bit         SIGNED    = 1'b0,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input wire          CLK,
    input wire          RESET,
    int_tx_dec_if.slave bus
);

    localparam int c_PW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int c_CW = $clog2(NBIT);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(NBIT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE  = c_PW'(1);
    localparam logic [NBIT-1:0] c_ONE      = NBIT'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_SIGN   = 3'd2,
        S_DIGITS = 3'd3,
        S_TERM   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NBIT-1:0]     r_bin;
    logic [4*NDIG-1:0]   r_bcd;
    logic [c_CW-1:0]     r_cnt;
    logic [c_PW-1:0]     r_ptr;
    logic                r_neg;

    logic                w_neg;
    logic [NBIT-1:0]     w_mag;
    logic [4*NDIG-1:0]   w_bcd_adj;
    logic [4*NDIG-1:0]   w_bcd_shift;
    logic [NBIT-1:0]     w_bin_shift;
    logic [c_PW-1:0]     w_msd;
    logic [3:0]          w_nib;
    logic                w_rd;
    logic                w_wr;
    logic [7:0]          w_data;

    // The most negative operand negates onto itself, which is its correct unsigned magnitude.
    assign w_neg = SIGNED && bus.DATO_ALU[NBIT-1];
    assign w_mag = w_neg ? (~bus.DATO_ALU + c_ONE) : bus.DATO_ALU;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_shift = {w_bcd_adj[4*NDIG-2:0], r_bin[NBIT-1]};
        w_bin_shift = {r_bin[NBIT-2:0], 1'b0};
    end

    // Highest non-zero digit of the finished conversion; zero maps to digit 0.
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w_bcd_shift[4*i +: 4] != 4'd0) begin
                w_msd = c_PW'(i);
            end
        end
    end

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_ptr == c_PW'(i)) begin
                w_nib = r_bcd[4*i +: 4];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_data      = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (bus.enviar) begin
                    w_rd        = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = r_neg ? S_SIGN : S_DIGITS;
                end
            end
            S_SIGN: begin
                w_data = 8'h2D;
                w_wr   = !bus.fifo_full;
                if (w_wr) begin
                    w_state_nxt = S_DIGITS;
                end
            end
            S_DIGITS: begin
                w_data = {4'h3, w_nib};
                w_wr   = !bus.fifo_full;
                if (w_wr && (r_ptr == '0)) begin
                    w_state_nxt = TERM_EN ? S_TERM : S_IDLE;
                end
            end
            S_TERM: begin
                w_data = TERM_CHAR;
                w_wr   = !bus.fifo_full;
                if (w_wr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ptr <= '0;
            r_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enviar) begin
                        r_bin <= w_mag;
                        r_neg <= w_neg;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CONV: begin
                    r_bin <= w_bin_shift;
                    r_bcd <= w_bcd_shift;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_ptr <= w_msd;
                    end
                end
                S_DIGITS: begin
                    if (w_wr && (r_ptr != '0)) begin
                        r_ptr <= r_ptr - c_PTR_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.RD_FIFO_IN  = w_rd;
    assign bus.WR_FIFO_OUT = w_wr;
    assign bus.data_fifo   = w_data;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.STATE       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_int_tx_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_tx_dec
// Purpose  : Drives three differently parameterised transmitters with shared
//            stimulus and compares every byte and its cycle with a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_tx_dec;

    localparam int c_FH = 65536;

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] c;
        logic [7:0]  b;
    } ev_t;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic        env   = 1'b0;
    logic [15:0] op    = 16'd0;
    logic        full_drv = 1'b0;
    int          cyc   = 0;
    int          full_mode = 0;
    int          win_s = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    bit          full_hist [c_FH];
    ev_t         wq[$];
    ev_t         rq[$];
    int          busy_cnt [3];
    logic [7:0]  exp_q[$];

    int nb [3] = '{16, 16, 8};
    bit sg [3] = '{1'b0, 1'b1, 1'b0};
    bit te [3] = '{1'b1, 1'b1, 1'b0};

    int_tx_dec_if #(.NBIT(16)) if0 ();
    int_tx_dec_if #(.NBIT(16)) if1 ();
    int_tx_dec_if #(.NBIT(8))  if2 ();

    assign if0.enviar = env;  assign if1.enviar = env;  assign if2.enviar = env;
    assign if0.fifo_full = full_drv; assign if1.fifo_full = full_drv; assign if2.fifo_full = full_drv;
    assign if0.DATO_ALU = op; assign if1.DATO_ALU = op; assign if2.DATO_ALU = op[7:0];

    int_tx_dec #(.NBIT(16), .NDIG(5), .SIGNED(1'b0), .TERM_EN(1'b1), .TERM_CHAR(8'h0A))
        u_dut0 (.CLK(CLK), .RESET(RESET), .bus(if0));
    int_tx_dec #(.NBIT(16), .NDIG(5), .SIGNED(1'b1), .TERM_EN(1'b1), .TERM_CHAR(8'h0A))
        u_dut1 (.CLK(CLK), .RESET(RESET), .bus(if1));
    int_tx_dec #(.NBIT(8), .NDIG(3), .SIGNED(1'b0), .TERM_EN(1'b0), .TERM_CHAR(8'h0A))
        u_dut2 (.CLK(CLK), .RESET(RESET), .bus(if2));

    logic [2:0]  wr_v, rd_v, busy_v;
    logic [7:0]  dat_v [3];
    logic [8:0]  st_v;
    assign wr_v   = {if2.WR_FIFO_OUT, if1.WR_FIFO_OUT, if0.WR_FIFO_OUT};
    assign rd_v   = {if2.RD_FIFO_IN, if1.RD_FIFO_IN, if0.RD_FIFO_IN};
    assign busy_v = {if2.busy, if1.busy, if0.busy};
    assign st_v   = {if2.STATE, if1.STATE, if0.STATE};
    assign dat_v[0] = if0.data_fifo;
    assign dat_v[1] = if1.data_fifo;
    assign dat_v[2] = if2.data_fifo;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        case (full_mode)
            1:       full_drv = ($urandom_range(0, 2) == 0);
            2:       full_drv = (cyc >= win_s) && (cyc < win_s + 3);
            default: full_drv = 1'b0;
        endcase
    end

    always @(negedge CLK) begin
        if (cyc < c_FH) full_hist[cyc] = full_drv;
        for (int d = 0; d < 3; d++) begin
            if (wr_v[d]) wq.push_back('{d: 2'(d), c: 32'(cyc), b: dat_v[d]});
            if (rd_v[d]) rq.push_back('{d: 2'(d), c: 32'(cyc), b: 8'h00});
            if (busy_v[d]) busy_cnt[d]++;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Decimal text the transmitter should produce for value v.
    task automatic mk_exp(input int n, input bit s, input bit t, input longint unsigned v);
        longint unsigned m;
        logic [7:0] dq[$];
        exp_q.delete();
        m = v;
        if (s && (((v >> (n - 1)) & 64'd1) == 64'd1)) begin
            exp_q.push_back(8'h2D);
            m = (64'd1 << n) - v;
        end
        do begin
            dq.push_front(8'(8'h30 + m % 10));
            m = m / 10;
        end while (m != 0);
        foreach (dq[i]) exp_q.push_back(dq[i]);
        if (t) exp_q.push_back(8'h0A);
    endtask

    task automatic clear_mon();
        wq.delete();
        rq.delete();
        for (int d = 0; d < 3; d++) busy_cnt[d] = 0;
    endtask

    task automatic run(input logic [15:0] v, input int mode, input bit poke);
        int t0, k, c, n, nr;
        bit done;
        int ecyc[$];
        @(posedge CLK); #1;
        clear_mon();
        t0 = cyc;
        op = v;
        env = 1'b1;
        full_mode = mode;
        win_s = t0 + 18;
        k = $urandom_range(1, 8);
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK); #1;
            env = poke && (i == k);
            op = 16'($urandom);
        end
        @(posedge CLK); #1;
        env = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK);
            if (busy_v == 3'b000) done = 1'b1;
        end
        check("idle_timeout", done, 1);
        full_mode = 0;
        for (int d = 0; d < 3; d++) begin
            mk_exp(nb[d], sg[d], te[d], (d == 2) ? longint'(v[7:0]) : longint'(v));
            ecyc.delete();
            c = t0 + nb[d] + 1;
            foreach (exp_q[i]) begin
                while (c < c_FH && full_hist[c]) c++;
                ecyc.push_back(c);
                c++;
            end
            n = 0;
            foreach (wq[j]) begin
                if (int'(wq[j].d) == d) begin
                    if (n < exp_q.size()) begin
                        check($sformatf("d%0d_byte%0d", d, n), wq[j].b, exp_q[n]);
                        check($sformatf("d%0d_wcyc%0d", d, n), wq[j].c, ecyc[n]);
                    end
                    n++;
                end
            end
            check($sformatf("d%0d_nbytes", d), n, exp_q.size());
            nr = 0;
            foreach (rq[j]) begin
                if (int'(rq[j].d) == d) begin
                    if (nr == 0) check($sformatf("d%0d_rd_cyc", d), rq[j].c, t0);
                    nr++;
                end
            end
            check($sformatf("d%0d_rd_cnt", d), nr, 1);
            check($sformatf("d%0d_busy", d), busy_cnt[d], ecyc[ecyc.size() - 1] - t0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr"},   wr_v, 0);
        check({tag, "_rd"},   rd_v, 0);
        check({tag, "_busy"}, busy_v, 0);
        check({tag, "_st"},   st_v, 0);
        check({tag, "_dat"},  {dat_v[2], dat_v[1], dat_v[0]}, 0);
    endtask

    // Abort in the middle of the 65535 digit stream.
    task automatic rst_test();
        @(posedge CLK); #1;
        clear_mon();
        op = 16'hFFFF;
        env = 1'b1;
        @(posedge CLK); #1;
        env = 1'b0;
        repeat (17) @(posedge CLK);
        @(negedge CLK);
        check("mid_wr", wr_v[0], 1);
        check("mid_dat", dat_v[0], 8'h35);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check_zero("rst_mid");
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_zero("rst_rel");
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check_zero("rst_init");
        @(posedge CLK); #1;
        RESET = 1'b0;
        run(16'd0,     0, 1'b0);
        run(16'd7,     0, 1'b0);
        run(16'd65535, 0, 1'b1);
        run(16'd1007,  0, 1'b0);
        run(16'hFFFB,  0, 1'b0);
        run(16'h8000,  0, 1'b0);
        run(16'h7FFF,  0, 1'b0);
        run(16'd12345, 2, 1'b0);
        run(16'd255,   0, 1'b0);
        rst_test();
        run(16'd4096,  0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run(16'($urandom), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
